// File: rtl/lab3_mem_line_mem_responder_if.sv
// lab3_mem_line_mem_responder_if: memreq/memresp valid-ready bundle.
// memreq_msg (175b) / memreq_val / memreq_rdy carry line requests from master to slave.
// memresp_msg (145b) / memresp_val / memresp_rdy carry line responses back to the master.
interface lab3_mem_line_mem_responder_if;
  logic [174:0] memreq_msg;
  logic         memreq_val;
  logic         memreq_rdy;
  logic [144:0] memresp_msg;
  logic         memresp_val;
  logic         memresp_rdy;
  modport master(output memreq_msg, memreq_val, memresp_rdy, input memreq_rdy, memresp_msg, memresp_val);
  modport slave(input memreq_msg, memreq_val, memresp_rdy, output memreq_rdy, memresp_msg, memresp_val);
endinterface

// File: rtl/lab3_mem_line_mem_responder.sv
// lab3_mem_line_mem_responder: 16B-line memory answering one request at a time after p_latency wait cycles.
// Ports: clk, reset (sync, active-high), mem (slave modport: memreq_* in, memresp_* out).
// Macro LINE_MEM_OOR_CHECK_EN: flag addresses above the line range with test=2'b11 and suppress their access.
module lab3_mem_line_mem_responder #(
  parameter int p_num_lines = 64,
  parameter int p_latency   = 0
) (
  input logic clk,
  input logic reset,
  lab3_mem_line_mem_responder_if.slave mem
);
  localparam int IW = $clog2(p_num_lines);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [144:0] resp_q, resp_d;
  logic [127:0] mem_q [p_num_lines];
  logic [127:0] mem_d [p_num_lines];
  logic [2:0] req_type;
  logic [7:0] req_opq;
  logic [31:0] req_addr;
  logic [3:0] req_len;
  logic [127:0] req_data, merged;
  logic [IW-1:0] idx;
  logic [4:0] nbytes;
  logic [1:0] test;
  logic acc, is_wr, bad, oor, unused_addr;
  assign {req_type, req_opq, req_addr, req_len, req_data} = mem.memreq_msg;
  assign idx = req_addr[4 +: IW];
  assign acc = mem.memreq_val && mem.memreq_rdy;
  assign unused_addr = ^req_addr;
`ifdef LINE_MEM_OOR_CHECK_EN
  assign oor = (req_addr >> (4 + IW)) != 32'd0;
`else
  assign oor = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && acc) begin
      state_d = (p_latency == 0) ? RESP : WAIT;
      cnt_d = 8'(p_latency);
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 8'd1;
      state_d = (cnt_q == 8'd1) ? RESP : WAIT;
    end else if (state_q == RESP && mem.memresp_rdy) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    mem.memreq_rdy = state_q == IDLE && !reset;
    mem.memresp_val = state_q == RESP;
    mem.memresp_msg = resp_q;
  end
  // Byte-masked merge: only the low nbytes of the request overwrite the stored line.
  always_comb begin
    nbytes = (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
    for (int b = 0; b < 16; b++) merged[8*b +: 8] = (5'(b) < nbytes) ? req_data[8*b +: 8] : mem_q[idx][8*b +: 8];
    is_wr = req_type == 3'd1 || req_type == 3'd2;
    bad = req_type > 3'd2;
    test = bad ? 2'b10 : oor ? 2'b11 : 2'b00;
    mem_d = mem_q;
    if (acc && is_wr && !oor) mem_d[idx] = merged;
    resp_d = acc ? {req_type, req_opq, test, req_len, (req_type == 3'd0 && !oor) ? mem_q[idx] : 128'd0} : resp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      resp_q <= '0;
      for (int i = 0; i < p_num_lines; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      resp_q <= resp_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: doc/lab3_mem_line_mem_responder.md
Name: lab3_mem_line_mem_responder

Overview:
- Behavioural line-granularity memory that sits on the memory side of the cache memreq/memresp port pair.
- Accepts one mem_req_16B_t at a time and performs the read, write or init on an internal line array.
- After a programmable fixed delay, returns a mem_resp_16B_t.
- Used as the refill/writeback target in cache unit tests and in the lab5 multi-bank composition.

Parameters:
- p_num_lines, 64, number of 16B lines stored; power of two, at least 2.
- p_latency, 0, extra wait cycles between request acceptance and response valid; range 0..255.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- memreq_msg  input  175 (mem_req_16B_t)  line request: type, opaque, addr, len, data
- memreq_val  input  1  request valid
- memreq_rdy  output  1  request ready
- memresp_msg  output  145 (mem_resp_16B_t)  line response: type, opaque, test, len, data
- memresp_val  output  1  response valid
- memresp_rdy  input  1  response ready

Behaviour:
- One clock (clk). Reset is synchronous, active-high (reset) and sampled on the rising clk edge.
- Reset values:
  - State goes to IDLE.
  - memreq_rdy=1 in the first cycle after reset deasserts (0 while reset is high).
  - memresp_val=0; memresp_msg all zero.
  - Line array cleared to zero; wait counter cleared to 0.
- Indexing: idx = addr[4+log2(p_num_lines)-1 : 4]. addr[3:0] is ignored and all accesses are line-aligned.
- len encoding: len=0 means 16 bytes; len=n means n bytes.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: memreq_rdy=1, memresp_val=0. On memreq_val&&memreq_rdy (acceptance cycle T0):
    - The access is performed at the T0 edge.
    - Response fields are latched: type, opaque, len echoed; test=2'b00.
    - Go to WAIT with counter=p_latency, or go straight to RESP if p_latency=0.
  - WAIT: memreq_rdy=0. Counter decrements each cycle; at counter==1 go to RESP.
  - RESP: memresp_val=1 and the message is held stable until memresp_rdy. On the handshake, go to IDLE.
- Response timing: memresp_val first rises in cycle T0+1+p_latency.
- Request rate: at most one outstanding request. Minimum request-to-request spacing is 2+p_latency cycles with memresp_rdy held high.
- Access semantics:
  - READ (type 0): resp data = line[idx].
  - WRITE (type 1): the low len bytes of data are written to line[idx] (all 16 bytes for len=0); resp data=0.
  - INIT (type 2): same as WRITE.
  - Any other type: no array update; resp data=0, test=2'b10.
- Read-after-write: a READ accepted after a WRITE to the same idx returns the new data. No forwarding is needed because requests are serialised.
- Backpressure: memresp_rdy low in RESP stalls indefinitely with the message held stable. memreq_val is ignored while not in IDLE.
- Reset mid-operation: the pending response is discarded and the FSM returns to IDLE. A write already performed at T0 is lost because the array is cleared.

Optional Feature:
- Macro: LINE_MEM_OOR_CHECK_EN.
- Defined: an address with any bit above the index range set (addr[31:4+log2(p_num_lines)] != 0) is out of range.
  - Out-of-range requests do not modify the array.
  - READ returns data=0.
  - The response carries test=2'b11. Timing is unchanged.
- Undefined: upper address bits are ignored, so addresses alias modulo p_num_lines lines, and test is always 2'b00 for valid types.

Test Plan:
- Reset, then READ addr 0x00000040, p_latency=0 -> memresp_val at T0+1; data=0, type=0, test=0, opaque echoed.
- WRITE addr 0x100 data 0x0123456789abcdef_fedcba9876543210 len=0, then READ 0x100 -> read returns the same 128b value; write response data=0, type=1.
- p_latency=3: READ accepted at cycle 10 -> memresp_val rises at cycle 14; memreq_rdy=0 in cycles 11-14.
- Hold memresp_rdy=0 for 5 cycles in RESP while memreq_val=1 -> response held stable; no second request accepted until the cycle after the response handshake.
- WRITE len=4 data=0x...AABBCCDD to a zeroed line, then READ -> data=0x000...00AABBCCDD.
- With LINE_MEM_OOR_CHECK_EN, p_num_lines=64: WRITE to 0x00000400, then READ 0x00000000 -> write response test=2'b11 and line 0 is still 0. Without the macro, the same sequence returns the written data from line 0.
